// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for a 5-stage in-order core.
// Detects load-use and branch-dependency hazards, and sequences the IF/ID
// flush after a PC redirect.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall and flush
// performance counters and their output ports.
module hazard_ctrl_unit #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned FLUSH_DEPTH = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead_EX,
   input  logic              RegWrite_EX,
   input  logic [REG_AW-1:0] RdAddress_EX,
   input  logic [REG_AW-1:0] RsAddress_ID,
   input  logic [REG_AW-1:0] RtAddress_ID,
   input  logic              IsBranch_ID,
   input  logic              Redirect,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              Stall,
   output logic              Flush
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  StallCount,
   output logic [CNT_W-1:0]  FlushCount
`endif
);

   typedef enum logic [1:0] {
      StIdle,
      StLdStall,
      StFlush
   } state_e;

   // Reload values: the cycle that enters a sequence already counts as one.
   localparam logic [3:0] LoadReload  = 4'(LOAD_LAT - 1);
   localparam logic [3:0] FlushReload = 4'(FLUSH_DEPTH - 1);

   state_e     r_state;
   state_e     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;

   logic w_match;
   logic w_load_use;
   logic w_br_dep;
   logic w_pc_write;
   logic w_if_id_write;
   logic w_stall;
   logic w_flush;

   // Register 0 is hard-wired, so it never creates a dependency.
   assign w_match = (RdAddress_EX != '0) &&
                    ((RdAddress_EX == RsAddress_ID) || (RdAddress_EX == RtAddress_ID));
   assign w_load_use = MemRead_EX && w_match;
   assign w_br_dep   = RegWrite_EX && !MemRead_EX && IsBranch_ID && w_match;

   // State and down-counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state and Mealy outputs; a redirect outranks any stall.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_stall       = 1'b0;
      w_flush       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (Redirect) begin
               w_flush       = 1'b1;
               w_if_id_write = 1'b0;
               if (FLUSH_DEPTH > 1) begin
                  w_state_nxt = StFlush;
                  w_cnt_nxt   = FlushReload;
               end
            end else if (w_load_use) begin
               w_stall       = 1'b1;
               w_pc_write    = 1'b0;
               w_if_id_write = 1'b0;
               if (LOAD_LAT > 1) begin
                  w_state_nxt = StLdStall;
                  w_cnt_nxt   = LoadReload;
               end
            end else if (w_br_dep) begin
               w_stall       = 1'b1;
               w_pc_write    = 1'b0;
               w_if_id_write = 1'b0;
            end
         end
         StLdStall: begin
            if (Redirect) begin
               // Abort the load stall; the remaining count is dropped.
               w_flush       = 1'b1;
               w_if_id_write = 1'b0;
               if (FLUSH_DEPTH > 1) begin
                  w_state_nxt = StFlush;
                  w_cnt_nxt   = FlushReload;
               end else begin
                  w_state_nxt = StIdle;
                  w_cnt_nxt   = 4'd0;
               end
            end else begin
               w_stall       = 1'b1;
               w_pc_write    = 1'b0;
               w_if_id_write = 1'b0;
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = StIdle;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
         end
         StFlush: begin
            // Hazards are not evaluated while squashing.
            w_flush       = 1'b1;
            w_if_id_write = 1'b0;
            if (Redirect) begin
               w_cnt_nxt = FlushReload;
            end else if (r_cnt <= 4'd1) begin
               w_state_nxt = StIdle;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Outputs are forced to their defaults while reset is held.
   assign PC_Write    = w_pc_write | ~rst_n;
   assign IF_ID_Write = w_if_id_write | ~rst_n;
   assign Stall       = w_stall & rst_n;
   assign Flush       = w_flush & rst_n;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (Stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (Flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal 1..8: stall cycles per load-use hazard.
REQ-003 Parameter FLUSH_DEPTH, default 1, legal 1..4: consecutive Flush cycles per redirect.
REQ-004 Parameter CNT_W, default 16: width of the performance counters.
REQ-005 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1: asynchronous, active-low reset.
REQ-007 Port MemRead_EX  input  1: the instruction in EX is a load.
REQ-008 Port RegWrite_EX  input  1: the instruction in EX writes a register.
REQ-009 Port RdAddress_EX  input  REG_AW: destination register of the EX instruction.
REQ-010 Port RsAddress_ID, RtAddress_ID  input  REG_AW each: source registers of the ID instruction.
REQ-011 Port IsBranch_ID  input  1: the ID instruction is a conditional branch resolved in ID.
REQ-012 Port Redirect  input  1: a taken branch or jump is changing the PC this cycle.
REQ-013 Port PC_Write  output  1: PC load enable.
REQ-014 Port IF_ID_Write  output  1: IF/ID register load enable.
REQ-015 Port Stall  output  1: insert a bubble into ID/EX (zero the control signals).
REQ-016 Port Flush  output  1: squash the IF/ID contents.
REQ-017 Port StallCount, FlushCount  output  CNT_W each: performance counters (present only per REQ-034).

Function
REQ-018 Match = (RdAddress_EX != 0) && (RdAddress_EX == RsAddress_ID || RdAddress_EX == RtAddress_ID); register 0 never produces a hazard.
REQ-019 FSM states: IDLE, LDSTALL, FLUSH; state and a 4-bit down-counter are registered, and the outputs are Mealy functions of state and inputs.
REQ-020 Default outputs, used when no rule applies: PC_Write=1, IF_ID_Write=1, Stall=0, Flush=0.
REQ-021 Priority in IDLE: Redirect > load-use > branch-dependency.
REQ-022 IDLE with Redirect=1: Flush=1, IF_ID_Write=0, PC_Write=1 this cycle; if FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1, else stay in IDLE.
REQ-023 IDLE with load-use (MemRead_EX && Match): Stall=1, PC_Write=0, IF_ID_Write=0 this cycle; if LOAD_LAT>1, go to LDSTALL with cnt=LOAD_LAT-1.
REQ-024 IDLE with branch-dependency (RegWrite_EX && !MemRead_EX && IsBranch_ID && Match): single-cycle stall with the REQ-023 outputs and no state change.
REQ-025 LDSTALL: Stall=1, PC_Write=0, IF_ID_Write=0; cnt decrements each cycle; at cnt==1 the next state is IDLE, giving exactly LOAD_LAT stall cycles in total.
REQ-026 LDSTALL with Redirect=1: the stall aborts; this cycle carries the REQ-022 outputs and transition, and the load-stall count is discarded.
REQ-027 FLUSH: Flush=1, IF_ID_Write=0, PC_Write=1; cnt decrements; at cnt==1 the next state is IDLE, giving exactly FLUSH_DEPTH Flush cycles in total.
REQ-028 FLUSH with a new Redirect: cnt reloads to FLUSH_DEPTH-1; hazards are ignored in FLUSH.
REQ-029 Stall and Flush are never both 1 in the same cycle.

Reset
REQ-030 rst_n low asynchronously forces state=IDLE, cnt=0 and both counters to 0.
REQ-031 While rst_n is low, the outputs are PC_Write=1, IF_ID_Write=1, Stall=0, Flush=0 regardless of the inputs.
REQ-032 Reset asserted mid-LDSTALL or mid-FLUSH abandons the sequence; after release the FSM is in IDLE.

Configuration
REQ-033 Macro HAZARD_PERF_CNT_EN selects the performance counters.
REQ-034 With HAZARD_PERF_CNT_EN defined: StallCount increments each cycle Stall=1, FlushCount increments each cycle Flush=1, both saturating at all-ones.
REQ-035 Without HAZARD_PERF_CNT_EN: the StallCount and FlushCount ports and their logic are absent, and all other behaviour is identical.

Verification
REQ-036 LOAD_LAT=3, MemRead_EX=1, RdAddress_EX=8, RsAddress_ID=8 for one cycle -> Stall=1, PC_Write=0 for exactly 3 cycles, then the default outputs.
REQ-037 MemRead_EX=1, RdAddress_EX=0, RtAddress_ID=0 -> no stall; RegWrite_EX=1, IsBranch_ID=1, RdAddress_EX=5, RsAddress_ID=5 -> exactly 1 stall cycle.
REQ-038 FLUSH_DEPTH=2, Redirect pulsed for 1 cycle -> Flush=1, IF_ID_Write=0 for 2 cycles; a second pulse during the second cycle -> 2 further Flush cycles.
REQ-039 LOAD_LAT=4, Redirect=1 in the second stall cycle -> Stall drops to 0 that cycle, Flush=1, and the FSM is in IDLE afterwards (FLUSH_DEPTH=1).
REQ-040 rst_n dropped in the middle of a LOAD_LAT=4 stall -> outputs go to their defaults immediately; after release with no hazard, Stall stays 0.
REQ-041 With HAZARD_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> StallCount=15 (saturated); also check that Stall and Flush are never asserted together.
